// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, parallel load, logical shift, rotate and arithmetic
// shift, with serial ports on both ends and a saturating shift-step counter.
module univ_shift_reg #(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             n_reset,
   input  logic             n_clr,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] par_in,
   input  logic             ser_in_r,
   input  logic             ser_in_l,
   output logic [WIDTH-1:0] Q,
   output logic             ser_out_r,
   output logic             ser_out_l,
   output logic [CNT_W-1:0] shift_cnt,
   output logic             done
);

   localparam logic [2:0] M_HOLD = 3'b000;
   localparam logic [2:0] M_SHR  = 3'b001;
   localparam logic [2:0] M_SHL  = 3'b010;
   localparam logic [2:0] M_LOAD = 3'b011;
   localparam logic [2:0] M_ROTR = 3'b100;
   localparam logic [2:0] M_ROTL = 3'b101;
   localparam logic [2:0] M_ASHR = 3'b110;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

   logic [WIDTH-1:0] r_q;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] w_q_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_step;

   // Next-state decode: clear beats enable, enable gates every mode
   always_comb begin
      w_q_nxt   = r_q;
      w_cnt_nxt = r_cnt;
      w_step    = 1'b0;
      if (!n_clr) begin
         w_q_nxt   = {WIDTH{1'b0}};
         w_cnt_nxt = {CNT_W{1'b0}};
      end else if (en) begin
         case (mode)
            M_HOLD: w_q_nxt = r_q;
            M_SHR: begin
               w_q_nxt = {ser_in_r, r_q[WIDTH-1:1]};
               w_step  = 1'b1;
            end
            M_SHL: begin
               w_q_nxt = {r_q[WIDTH-2:0], ser_in_l};
               w_step  = 1'b1;
            end
            M_LOAD: begin
               w_q_nxt   = par_in;
               w_cnt_nxt = {CNT_W{1'b0}};
            end
            M_ROTR: begin
               w_q_nxt = {r_q[0], r_q[WIDTH-1:1]};
               w_step  = 1'b1;
            end
            M_ROTL: begin
               w_q_nxt = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
               w_step  = 1'b1;
            end
            M_ASHR: begin
               w_q_nxt = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
               w_step  = 1'b1;
            end
            default: w_q_nxt = r_q;
         endcase
         // Counter stops at WIDTH so done stays asserted while shifting continues
         if (w_step && (r_cnt != CNT_MAX)) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
         end else begin
            w_cnt_nxt = w_cnt_nxt;
         end
      end else begin
         w_q_nxt   = r_q;
         w_cnt_nxt = r_cnt;
      end
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_q   <= {WIDTH{1'b0}};
         r_cnt <= {CNT_W{1'b0}};
      end else begin
         r_q   <= w_q_nxt;
         r_cnt <= w_cnt_nxt;
      end
   end

   assign Q         = r_q;
   assign shift_cnt = r_cnt;
   assign done      = (r_cnt == CNT_MAX);
   assign ser_out_r = r_q[0];
   assign ser_out_l = r_q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed testbench for univ_shift_reg (WIDTH=8) with hand-computed expectations.
module tb_univ_shift_reg;

   logic       clk;
   logic       n_reset;
   logic       n_clr;
   logic       en;
   logic [2:0] mode;
   logic [7:0] par_in;
   logic       ser_in_r;
   logic       ser_in_l;
   logic [7:0] Q;
   logic       ser_out_r;
   logic       ser_out_l;
   logic [3:0] shift_cnt;
   logic       done;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [2:0] HOLD = 3'b000, SHR = 3'b001, SHL = 3'b010, LOAD = 3'b011;
   localparam logic [2:0] ROTR = 3'b100, ROTL = 3'b101, ASHR = 3'b110;

   univ_shift_reg #(.WIDTH(8)) dut (
      .clk       (clk),
      .n_reset   (n_reset),
      .n_clr     (n_clr),
      .en        (en),
      .mode      (mode),
      .par_in    (par_in),
      .ser_in_r  (ser_in_r),
      .ser_in_l  (ser_in_l),
      .Q         (Q),
      .ser_out_r (ser_out_r),
      .ser_out_l (ser_out_l),
      .shift_cnt (shift_cnt),
      .done      (done)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Apply one operation at the falling edge, then sample 1ns after the rising edge
   task automatic step(input logic [2:0] m, input logic [7:0] p, input logic sr,
                       input logic sl, input logic e, input logic nc);
      @(negedge clk);
      mode = m; par_in = p; ser_in_r = sr; ser_in_l = sl; en = e; n_clr = nc;
      @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string tag, input logic [7:0] q, input logic [3:0] c,
                              input logic d);
      check_val({tag, "_q"}, 32'(Q), 32'(q));
      check_val({tag, "_cnt"}, 32'(shift_cnt), 32'(c));
      check_val({tag, "_done"}, 32'(done), 32'(d));
   endtask

   logic [7:0] exp_sr;

   initial begin
      n_reset = 1'b0; n_clr = 1'b1; en = 1'b0; mode = HOLD;
      par_in = 8'h00; ser_in_r = 1'b0; ser_in_l = 1'b0;
      #1;
      check_state("por", 8'h00, 4'd0, 1'b0);
      @(negedge clk);
      n_reset = 1'b1;

      // Asynchronous reset between edges with Q = 0xA5
      step(LOAD, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1);
      check_val("load_a5", 32'(Q), 32'h000000A5);
      @(negedge clk);
      mode = HOLD;
      #2 n_reset = 1'b0;
      #1 check_state("async_rst", 8'h00, 4'd0, 1'b0);
      #3 n_reset = 1'b1;
      @(posedge clk); #1;
      check_val("post_rst_hold", 32'(Q), 32'h0);

      // LOAD 0xB4 then shift right out through ser_out_r
      step(LOAD, 8'hB4, 1'b0, 1'b0, 1'b1, 1'b1);
      check_state("load_b4", 8'hB4, 4'd0, 1'b0);
      exp_sr = 8'b1011_0100;
      for (int i = 0; i < 8; i++) begin
         check_val($sformatf("ser_out_r_%0d", i), 32'(ser_out_r), 32'(exp_sr[i]));
         step(SHR, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
         if (i == 6) check_state("shr7", 8'h01, 4'd7, 1'b0);
      end
      check_state("shr8", 8'h00, 4'd8, 1'b1);
      step(SHR, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
      check_state("shr9_sat", 8'h80, 4'd8, 1'b1);
      check_val("ser_out_l", 32'(ser_out_l), 32'd1);

      // Rotates
      step(LOAD, 8'h81, 1'b0, 1'b0, 1'b1, 1'b1);
      step(ROTL, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      check_val("rotl", 32'(Q), 32'h03);
      step(ROTR, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      check_state("rotr", 8'h81, 4'd2, 1'b0);

      // Arithmetic shift right keeps the sign bit
      step(LOAD, 8'h90, 1'b0, 1'b0, 1'b1, 1'b1);
      step(ASHR, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      check_val("ashr1", 32'(Q), 32'hC8);
      step(ASHR, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      check_state("ashr2", 8'hE4, 4'd2, 1'b0);

      // Shift left with serial input, and reserved mode behaves as hold
      step(LOAD, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1);
      step(SHL, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
      check_state("shl_in1", 8'h03, 4'd1, 1'b0);
      step(3'b111, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1);
      check_state("reserved", 8'h03, 4'd1, 1'b0);

      // Enable gating
      step(LOAD, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) step(SHR, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
      check_state("en_gate", 8'h3C, 4'd0, 1'b0);

      // Synchronous clear acts only at the edge, and beats LOAD
      @(negedge clk);
      en = 1'b0; n_clr = 1'b0;
      #2 check_val("clr_not_before_edge", 32'(Q), 32'h3C);
      @(posedge clk); #1;
      check_state("clr", 8'h00, 4'd0, 1'b0);
      step(LOAD, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
      check_val("clr_vs_load", 32'(Q), 32'h00);

      // Clear also resets a running count
      step(LOAD, 8'h0F, 1'b0, 1'b0, 1'b1, 1'b1);
      step(SHR, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      step(SHR, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      check_val("cnt_before_clr", 32'(shift_cnt), 32'd2);
      step(SHR, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      check_state("clr_cnt", 8'h00, 4'd0, 1'b0);

      // Reset pulse in the middle of a shift sequence
      step(LOAD, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1);
      step(SHL, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      step(SHL, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      step(SHL, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      check_state("shl3", 8'hD0, 4'd3, 1'b0);
      #1 n_reset = 1'b0;
      #1 check_state("mid_rst", 8'h00, 4'd0, 1'b0);
      #9 n_reset = 1'b1;
      step(LOAD, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1);
      check_state("load_after_rst", 8'h11, 4'd0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parameterised universal shift register built from the team's enabled, clearable D flip-flop stage. One register of WIDTH bits sits directly downstream of that single-bit stage.
- Supports hold, parallel load, logical shift, rotate and arithmetic shift, with serial in/out on both ends.
- Tracks how many shift steps have happened since the last load. Flags `done` once all loaded bits have been shifted out, so a parallel-to-serial consumer can frame words without an external counter.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), width of shift counter. Derived; must not be overridden.

Ports:
- clk  input  1  rising-edge clock.
- n_reset  input  1  asynchronous active-low reset.
- n_clr  input  1  synchronous active-low clear; acts regardless of en.
- en  input  1  clock enable for all mode operations.
- mode  input  3  operation select (see Behaviour).
- par_in  input  WIDTH  parallel load data.
- ser_in_r  input  1  serial input entering Q[WIDTH-1] on shift right.
- ser_in_l  input  1  serial input entering Q[0] on shift left.
- Q  output  WIDTH  register contents.
- ser_out_r  output  1  equals Q[0] (combinational from Q).
- ser_out_l  output  1  equals Q[WIDTH-1] (combinational from Q).
- shift_cnt  output  CNT_W  shift/rotate steps since last load, clear or reset; saturates at WIDTH.
- done  output  1  high when shift_cnt == WIDTH.

Behaviour:
- Reset values (n_reset=0, asynchronous, immediate): Q=0, shift_cnt=0, done=0. These hold while n_reset is low.
- Priority at each rising clk: n_reset > n_clr > en > mode.
- n_clr=0 at the edge: Q<=0, shift_cnt<=0; en and mode are ignored.
- en=0 (and n_clr=1): Q and shift_cnt hold.
- en=1 mode decode; all shifts are 1 bit per cycle:
  - 000 HOLD: no change.
  - 001 SHR: Q <= {ser_in_r, Q[WIDTH-1:1]}.
  - 010 SHL: Q <= {Q[WIDTH-2:0], ser_in_l}.
  - 011 LOAD: Q <= par_in; shift_cnt <= 0.
  - 100 ROTR: Q <= {Q[0], Q[WIDTH-1:1]}.
  - 101 ROTL: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}.
  - 110 ASHR: Q <= {Q[WIDTH-1], Q[WIDTH-1:1]}.
  - 111: reserved, behaves as HOLD.
- Counter: modes 001, 010, 100, 101, 110 with en=1 increment shift_cnt by 1, saturating at WIDTH (no wrap). HOLD and reserved leave it unchanged.
- done is decoded from the registered shift_cnt. It rises in the cycle after the WIDTH-th shift edge and stays high until the next LOAD, clear or reset.
- Shifts continue to modify Q after done; only the counter saturates.
- Latency: Q, shift_cnt and done update 1 clk after the qualifying edge. ser_out_* follow Q with no added latency.
- Deassertion of n_reset mid-cycle: the register takes no action until the next rising edge.
- Assertion of n_reset mid-operation: everything is cleared at once, including during a shift sequence with done high.
- Simultaneous n_clr=0 with LOAD: clear wins, so Q=0 and par_in is discarded.
- Inputs are sampled only at rising clk; glitches between edges have no effect.

Test Plan:
- Reset: drive n_reset=0 at t=5ns with Q previously 0xA5 -> Q=0x00, shift_cnt=0, done=0 immediately, before any clk edge.
- Load then SHR: en=1, LOAD 0xB4, then 8 cycles of SHR with ser_in_r=0.
  - ser_out_r sequence is 0,0,1,0,1,1,0,1.
  - Q ends at 0x00, shift_cnt=8, done=1.
  - A 9th SHR keeps shift_cnt=8.
- Rotate and ASHR:
  - LOAD 0x81, ROTL -> 0x03; ROTR -> 0x81.
  - LOAD 0x90, ASHR twice -> 0xC8 then 0xE4; shift_cnt=2.
- Enable gating: LOAD 0x3C, set en=0, mode=001 for 3 cycles -> Q stays 0x3C, shift_cnt stays 0.
- Sync clear vs load: en=0, n_clr=0 -> Q=0x00 at the next edge, not before. Then en=1, mode=011, par_in=0xFF with n_clr=0 -> Q stays 0x00.
- Reset mid-shift: after LOAD 0x5A and 3 SHL, pulse n_reset low for 10ns between edges -> Q=0, shift_cnt=0 immediately. Next LOAD 0x11 -> Q=0x11.
